// File: rtl/psum_accumulate_writer.sv
// psum_accumulate_writer: read-modify-write psum accumulator, 3-stage
// pipeline (A accept/read, B add, C write) with C/D address forwarding.
// Ports: clk, reset (async, active-high); in_* tuple handshake with
//   in_ready/await; mem_rd_*/mem_wr_* to a read-first synchronous SRAM;
//   busy (RUN/DRAIN) and done (one-cycle pulse after the last write).
// Optional macro PSUM_SATURATE_EN: signed saturating add in stage B.
module psum_accumulate_writer #(
  parameter int n_WIDTH = 3,
  parameter int p_WIDTH = 5,
  parameter int t_WIDTH = 3,
  parameter int E_WIDTH = 6,
  parameter int F_WIDTH = 6,
  parameter int D_WIDTH = 16,
  localparam int A_WIDTH =
    n_WIDTH + p_WIDTH + t_WIDTH + E_WIDTH + F_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       await,
  input  logic [n_WIDTH-1:0]         in_psum_index,
  input  logic [p_WIDTH+t_WIDTH-1:0] in_channel_index,
  input  logic [E_WIDTH-1:0]         in_row_index,
  input  logic [F_WIDTH-1:0]         in_col_index,
  input  logic [D_WIDTH-1:0]         in_data,
  input  logic                       in_first,
  input  logic                       in_last,
  output logic                       mem_rd_en,
  output logic [A_WIDTH-1:0]         mem_rd_addr,
  input  logic [D_WIDTH-1:0]         mem_rd_data,
  output logic                       mem_wr_en,
  output logic [A_WIDTH-1:0]         mem_wr_addr,
  output logic [D_WIDTH-1:0]         mem_wr_data,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic               accept;
  logic [A_WIDTH-1:0] in_addr;

  logic               b_valid;
  logic [A_WIDTH-1:0] b_addr;
  logic [D_WIDTH-1:0] b_data;
  logic               b_first;

  logic               c_valid;
  logic [A_WIDTH-1:0] c_addr;
  logic [D_WIDTH-1:0] c_data;

  logic               d_valid;
  logic [A_WIDTH-1:0] d_addr;
  logic [D_WIDTH-1:0] d_data;

  logic [D_WIDTH-1:0] operand;
  logic [D_WIDTH-1:0] sum;

  assign in_addr = {in_psum_index, in_channel_index,
                    in_row_index, in_col_index};

  assign in_ready = (state == IDLE) || (state == RUN);
  assign await    = ~in_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  assign mem_rd_en   = accept && !in_first;
  assign mem_rd_addr = in_addr;

  assign mem_wr_en   = c_valid;
  assign mem_wr_addr = c_addr;
  assign mem_wr_data = c_data;

  // C holds the write on the bus this cycle, D the one committed last
  // edge; the read for B missed both, so the newest matching one wins.
  always_comb begin
    operand = mem_rd_data;
    if (b_first) begin
      operand = '0;
    end else if (c_valid && (c_addr == b_addr)) begin
      operand = c_data;
    end else if (d_valid && (d_addr == b_addr)) begin
      operand = d_data;
    end
  end

`ifdef PSUM_SATURATE_EN
  localparam logic [D_WIDTH-1:0] SAT_MAX =
    {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic [D_WIDTH-1:0] SAT_MIN =
    {1'b1, {(D_WIDTH-1){1'b0}}};

  logic [D_WIDTH:0] sum_wide;

  // One guard bit: overflow when it disagrees with the sign bit.
  always_comb begin
    sum_wide = {operand[D_WIDTH-1], operand}
             + {b_data[D_WIDTH-1], b_data};
    sum = sum_wide[D_WIDTH-1:0];
    if (sum_wide[D_WIDTH] != sum_wide[D_WIDTH-1]) begin
      sum = sum_wide[D_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum = operand + b_data;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = in_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept && in_last) begin
          state_nx = DRAIN;
        end
      end
      // No accepts in DRAIN, so once B is empty C holds the final
      // write and both stages are empty after this edge.
      DRAIN: begin
        if (!b_valid) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid <= 1'b0;
      b_addr  <= '0;
      b_data  <= '0;
      b_first <= 1'b0;
      c_valid <= 1'b0;
      c_addr  <= '0;
      c_data  <= '0;
      d_valid <= 1'b0;
      d_addr  <= '0;
      d_data  <= '0;
    end else begin
      b_valid <= accept;
      if (accept) begin
        b_addr  <= in_addr;
        b_data  <= in_data;
        b_first <= in_first;
      end
      c_valid <= b_valid;
      if (b_valid) begin
        c_addr <= b_addr;
        c_data <= sum;
      end
      d_valid <= c_valid;
      if (c_valid) begin
        d_addr <= c_addr;
        d_data <= c_data;
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulate_writer.sv
// tb_psum_accumulate_writer: directed bench with a read-first SRAM model.
// Covers overwrite, C/D forwarding, memory read, overflow, drain, reset.
module tb_psum_accumulate_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        await;
  logic [2:0]  in_psum_index;
  logic [7:0]  in_channel_index;
  logic [5:0]  in_row_index;
  logic [5:0]  in_col_index;
  logic [15:0] in_data;
  logic        in_first;
  logic        in_last;
  logic        mem_rd_en;
  logic [22:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        mem_wr_en;
  logic [22:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [logic [22:0]];
  logic        preload_req = 1'b0;
  logic [22:0] preload_addr = '0;
  logic [15:0] preload_val = '0;

  always #5 clk = ~clk;

  psum_accumulate_writer dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .await            (await),
    .in_psum_index    (in_psum_index),
    .in_channel_index (in_channel_index),
    .in_row_index     (in_row_index),
    .in_col_index     (in_col_index),
    .in_data          (in_data),
    .in_first         (in_first),
    .in_last          (in_last),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data),
    .busy             (busy),
    .done             (done)
  );

  // Read-first SRAM: the read is sampled before the same-edge write.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem.exists(mem_rd_addr) ?
                     mem[mem_rd_addr] : 16'h0000;
    end
    if (mem_wr_en) begin
      mem[mem_wr_addr] = mem_wr_data;
    end
    if (preload_req) begin
      mem[preload_addr] = preload_val;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [22:0] a,
                     input logic [15:0] d,
                     input logic f, input logic l);
    @(posedge clk);
    #1;
    in_valid = v;
    {in_psum_index, in_channel_index,
     in_row_index, in_col_index} = a;
    in_data  = d;
    in_first = f;
    in_last  = l;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 23'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_wr(input string tag, input logic [22:0] a,
                        input logic [15:0] d);
    chk({tag, "_en"}, 32'(mem_wr_en), 32'h1);
    chk({tag, "_addr"}, 32'(mem_wr_addr), 32'(a));
    chk({tag, "_data"}, 32'(mem_wr_data), 32'(d));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'h1);
    chk({tag, "_await"}, 32'(await), 32'h0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'h0);
    chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'h0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'h0);
    chk({tag, "_wr_addr"}, 32'(mem_wr_addr), 32'h0);
    chk({tag, "_wr_data"}, 32'(mem_wr_data), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_psum_index    = '0;
    in_channel_index = '0;
    in_row_index     = '0;
    in_col_index     = '0;
    in_data          = '0;
    in_first         = 1'b0;
    in_last          = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    reset = 1'b0;
    idle();
    chk_reset_outs("rst_rel");

    // Four overwrites at distinct addresses.
    for (int i = 0; i < 6; i++) begin
      cyc(i < 4, 23'(23'h100 + i), 16'(i + 1), 1'b1, 1'b0);
      chk("t1_rd_en", 32'(mem_rd_en), 32'h0);
      if (i >= 2) begin
        chk_wr("t1_wr", 23'(23'h100 + i - 2), 16'(i - 1));
      end else begin
        chk("t1_wr_idle", 32'(mem_wr_en), 32'h0);
      end
    end
    chk("t1_busy", 32'(busy), 32'h1);

    // Back-to-back same address: forwarding from C.
    cyc(1'b1, 23'h10, 16'd5, 1'b1, 1'b0);
    cyc(1'b1, 23'h10, 16'd3, 1'b0, 1'b0);
    chk("t2_rd_en", 32'(mem_rd_en), 32'h1);
    cyc(1'b1, 23'h10, 16'd7, 1'b0, 1'b0);
    chk_wr("t2_w0", 23'h10, 16'd5);
    chk("t2_ready", 32'(in_ready), 32'h1);
    idle();
    chk_wr("t2_w1", 23'h10, 16'd8);
    idle();
    chk_wr("t2_w2", 23'h10, 16'd15);
    idle();
    chk("t2_wr_off", 32'(mem_wr_en), 32'h0);

    // Same address two apart: forwarding from D.
    cyc(1'b1, 23'h20, 16'd2, 1'b1, 1'b0);
    cyc(1'b1, 23'h21, 16'd9, 1'b1, 1'b0);
    cyc(1'b1, 23'h20, 16'd6, 1'b0, 1'b0);
    chk_wr("t3_w0", 23'h20, 16'd2);
    idle();
    chk_wr("t3_w1", 23'h21, 16'd9);
    idle();
    chk_wr("t3_w2", 23'h20, 16'd8);

    // Same address three apart reads memory; fresh address reads 0.
    cyc(1'b1, 23'h22, 16'd1, 1'b1, 1'b0);
    cyc(1'b1, 23'h23, 16'd1, 1'b1, 1'b0);
    cyc(1'b1, 23'h77, 16'd9, 1'b0, 1'b0);
    cyc(1'b1, 23'h22, 16'd4, 1'b0, 1'b0);
    chk("t3m_rd_en", 32'(mem_rd_en), 32'h1);
    idle();
    chk_wr("t3m_w77", 23'h77, 16'd9);
    idle();
    chk_wr("t3m_w22", 23'h22, 16'd5);

    // Overflow: positive and negative.
    preload_addr = 23'h30;
    preload_val  = 16'h7FFF;
    preload_req  = 1'b1;
    idle();
    preload_addr = 23'h31;
    preload_val  = 16'h8000;
    idle();
    preload_req  = 1'b0;
    cyc(1'b1, 23'h30, 16'h0001, 1'b0, 1'b0);
    cyc(1'b1, 23'h31, 16'hFFFF, 1'b0, 1'b0);
    idle();
`ifdef PSUM_SATURATE_EN
    chk_wr("t4_pos", 23'h30, 16'h7FFF);
    idle();
    chk_wr("t4_neg", 23'h31, 16'h8000);
`else
    chk_wr("t4_pos", 23'h30, 16'h8000);
    idle();
    chk_wr("t4_neg", 23'h31, 16'h7FFF);
`endif
    idle();

    // Last tuple, drain and done; a tuple offered in DRAIN is ignored.
    cyc(1'b1, 23'h40, 16'd3, 1'b1, 1'b1);
    chk("t5_n_await", 32'(await), 32'h0);
    chk("t5_n_ready", 32'(in_ready), 32'h1);
    cyc(1'b1, 23'h41, 16'd5, 1'b1, 1'b0);
    chk("t5_n1_await", 32'(await), 32'h1);
    chk("t5_n1_busy", 32'(busy), 32'h1);
    chk("t5_n1_rd_en", 32'(mem_rd_en), 32'h0);
    idle();
    chk_wr("t5_n2_wr", 23'h40, 16'd3);
    chk("t5_n2_await", 32'(await), 32'h1);
    chk("t5_n2_done", 32'(done), 32'h0);
    idle();
    chk("t5_n3_done", 32'(done), 32'h1);
    chk("t5_n3_busy", 32'(busy), 32'h0);
    chk("t5_n3_await", 32'(await), 32'h1);
    chk("t5_n3_wr_en", 32'(mem_wr_en), 32'h0);
    idle();
    chk("t5_n4_done", 32'(done), 32'h0);
    chk("t5_n4_await", 32'(await), 32'h0);
    chk("t5_n4_ready", 32'(in_ready), 32'h1);

    // Reset one cycle after accept discards the in-flight write.
    cyc(1'b1, 23'h50, 16'd7, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {in_psum_index, in_channel_index,
     in_row_index, in_col_index} = 23'h0;
    in_data  = '0;
    in_first = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk_reset_outs("t6_rst");
    @(negedge clk);
    chk_reset_outs("t6_rst2");
    reset = 1'b0;
    idle();
    chk("t6_wr_off0", 32'(mem_wr_en), 32'h0);
    idle();
    chk("t6_wr_off1", 32'(mem_wr_en), 32'h0);
    chk("t6_mem50", 32'(mem.exists(23'h50)), 32'h0);

    // A fresh single-tuple pass completes normally.
    cyc(1'b1, 23'h60, 16'd11, 1'b1, 1'b1);
    idle();
    idle();
    chk_wr("t6_pass_wr", 23'h60, 16'd11);
    idle();
    chk("t6_pass_done", 32'(done), 32'h1);
    idle();
    chk("t6_pass_ready", 32'(in_ready), 32'h1);
    chk("t6_pass_done_off", 32'(done), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
